pipelined_cla_adder: RTL and testbench

Parametrised, three-stage pipelined two-level carry-lookahead adder with a valid/ready handshake. It generalises the 4-bit lookahead cell to any `WIDTH` built from `GROUP`-bit groups, and adds registered stages, backpressure and signed-overflow reporting. It is intended as the adder datapath for area/timing comparison runs and for any unit that needs a registered wide adder.

---
 rtl/cla_adder_pkg.sv | 17 +
 rtl/cla_group_lookahead.sv | 55 +++++
 rtl/pipelined_cla_adder.sv | 190 +++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_adder_pkg.sv
// cla_adder_pkg
//   Shared constants and elaboration helpers for pipelined_cla_adder.
//   - CLA_STAGES   : number of registered compute stages after the input rank.
//   - cla_width_ok : WIDTH/GROUP legality rule, evaluated at elaboration.
//   The stage payload structs depend on the top's WIDTH/GROUP parameters.
//   A package cannot see those parameters, so the structs are declared in the
//   top module next to the registers that use them.
package cla_adder_pkg;

    localparam int CLA_STAGES = 3;

    // WIDTH must be a positive, whole number of lookahead groups.
    function automatic bit cla_width_ok(input int width, input int group);
        return (group > 0) && (width > 0) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group_lookahead.sv
// cla_group_lookahead
//   N-bit carry-lookahead cell using flat sum-of-products carries.
//   Ports:
//     p, g   : per-position propagate / generate
//     cin    : carry into position 0
//     p_blk  : block propagate (all positions propagate)
//     g_blk  : block generate (block produces a carry on its own)
//     c      : c[i] = carry into position i, c[N] = carry out of the block
module cla_group_lookahead #(
    parameter int N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic         p_blk,
    output logic         g_blk,
    output logic [N:0]   c
);

    // Each carry is an OR of independent product terms rather than a chain,
    // so the depth per carry stays two levels regardless of position.
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= N; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & p[k];
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    always_comb begin
        logic term;
        term  = 1'b0;
        g_blk = 1'b0;
        for (int j = 0; j < N; j++) begin
            term = g[j];
            for (int k = j + 1; k < N; k++) term = term & p[k];
            g_blk = g_blk | term;
        end
    end

    assign p_blk = &p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Registered two-level carry-lookahead adder with valid/ready handshake.
//   Ranks: input capture, S1 (p/g + group P/G), S2 (all carries), S3 (outputs).
//   An operand accepted at edge N shows valid_o after edge N+3.
//   Ports:
//     clk_i, rst_ni      : clock, asynchronous active-low reset
//     valid_i / ready_o  : operand handshake (ready_o = !valid_o | ready_i)
//     a_i, b_i, cin_i    : operands and carry-in (borrow-in when subtracting)
//     sub_i              : subtract select, only with CLA_ADDER_SUB_EN
//     valid_o / ready_i  : result handshake
//     sum_o, cout_o      : result and carry-out (borrow-out when subtracting)
//     ovf_o              : two's-complement overflow from raw carries
//   Optional feature macro: CLA_ADDER_SUB_EN
module pipelined_cla_adder
    import cla_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef CLA_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NGRP = WIDTH / GROUP;

    if (!cla_width_ok(WIDTH, GROUP)) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;    // B already conditioned for subtract
        logic             cin;  // effective carry-in
`ifdef CLA_ADDER_SUB_EN
        logic             sub;
`endif
    } in_t;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic             cin;
`ifdef CLA_ADDER_SUB_EN
        logic             sub;
`endif
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;    // c[i] = carry into bit i, c[WIDTH] = carry out
`ifdef CLA_ADDER_SUB_EN
        logic             sub;
`endif
    } s2_t;

    logic [CLA_STAGES:0] vld_pipe;
    logic                en;
    in_t                 in_d, in_q;
    s1_t                 s1_d, s1_q;
    s2_t                 s2_d, s2_q;
    logic                sub_s2;

    // Uniform stall: every rank moves together, bubbles are kept.
    assign en      = !vld_pipe[CLA_STAGES] || ready_i;
    assign ready_o = en;
    assign valid_o = vld_pipe[CLA_STAGES];

    // ---------------- input conditioning ----------------
    always_comb begin
        in_d.a = a_i;
`ifdef CLA_ADDER_SUB_EN
        in_d.b   = sub_i ? ~b_i : b_i;
        in_d.cin = cin_i ^ sub_i;
        in_d.sub = sub_i;
`else
        in_d.b   = b_i;
        in_d.cin = cin_i;
`endif
    end

    // ---------------- S1: bit p/g and group P/G ----------------
    logic [NGRP-1:0][GROUP:0] grp_c;  // group-local carries, recomputed in S2

    always_comb begin
        s1_d.p   = in_q.a ^ in_q.b;
        s1_d.g   = in_q.a & in_q.b;
        s1_d.cin = in_q.cin;
`ifdef CLA_ADDER_SUB_EN
        s1_d.sub = in_q.sub;
`endif
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group_lookahead #(.N(GROUP)) u_grp (
            .p     (s1_d.p[k*GROUP +: GROUP]),
            .g     (s1_d.g[k*GROUP +: GROUP]),
            .cin   (1'b0),
            .p_blk (s1_d.gp[k]),
            .g_blk (s1_d.gg[k]),
            .c     (grp_c[k])
        );
    end

    // ---------------- S2: group carries, then bit carries ----------------
    logic [NGRP:0]            gc;
    logic                     top_p, top_g;
    logic [NGRP-1:0]          bit_p, bit_g, bit_cout;
    logic [NGRP-1:0][GROUP:0] bit_c;
    logic [WIDTH-1:0]         bit_carry;

    cla_group_lookahead #(.N(NGRP)) u_top (
        .p     (s1_q.gp),
        .g     (s1_q.gg),
        .cin   (s1_q.cin),
        .p_blk (top_p),
        .g_blk (top_g),
        .c     (gc)
    );

    for (genvar k = 0; k < NGRP; k++) begin : g_bit
        cla_group_lookahead #(.N(GROUP)) u_bit (
            .p     (s1_q.p[k*GROUP +: GROUP]),
            .g     (s1_q.g[k*GROUP +: GROUP]),
            .cin   (gc[k]),
            .p_blk (bit_p[k]),
            .g_blk (bit_g[k]),
            .c     (bit_c[k])
        );
        assign bit_carry[k*GROUP +: GROUP] = bit_c[k][GROUP-1:0];
        // Group carry-out duplicates gc[k+1]; only the top-level one is used.
        assign bit_cout[k] = bit_c[k][GROUP];
    end

    always_comb begin
        s2_d.p = s1_q.p;
        s2_d.c = {gc[NGRP], bit_carry};
`ifdef CLA_ADDER_SUB_EN
        s2_d.sub = s1_q.sub;
`endif
    end

`ifdef CLA_ADDER_SUB_EN
    assign sub_s2 = s2_q.sub;
`else
    assign sub_s2 = 1'b0;
`endif

    // Block P/G outputs not needed at these levels are folded into one sink.
    logic unused_ok;
    assign unused_ok = ^{grp_c, top_p, top_g, bit_p, bit_g, bit_cout};

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            in_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            sum_o    <= '0;
            cout_o   <= 1'b0;
            ovf_o    <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[CLA_STAGES-1:0], valid_i};
            if (valid_i)     in_q <= in_d;
            if (vld_pipe[0]) s1_q <= s1_d;
            if (vld_pipe[1]) s2_q <= s2_d;
            if (vld_pipe[2]) begin
                sum_o  <= s2_q.p ^ s2_q.c[WIDTH-1:0];
                cout_o <= s2_q.c[WIDTH] ^ sub_s2;
                ovf_o  <= s2_q.c[WIDTH] ^ s2_q.c[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Directed and random checks of pipelined_cla_adder (WIDTH=32, GROUP=4)
//   against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_cla_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] a_i     = '0;
    logic [31:0] b_i     = '0;
    logic        cin_i   = 1'b0;
    logic        sub_i   = 1'b0;
    logic        ready_o, valid_o, cout_o, ovf_o;
    logic [31:0] sum_o;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_res = 0;
    exp_t q[$];
    bit   front_seen = 0;
    bit   hold_chk = 0;
    bit   chk_lat = 1;
    logic [31:0] prev_sum, last_sum;
    logic        prev_cout, prev_ovf, last_cout, last_ovf;

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
`ifdef CLA_ADDER_SUB_EN
        .sub_i   (sub_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic; overflow = true signed result out of range.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [32:0] u;
        longint      s;
        if (sub) begin
            u = {1'b0, a} - {1'b0, b} - {32'd0, cin};
            s = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        end else begin
            u = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.sum  = u[31:0];
        e.cout = u[32];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.acc  = 0;
        return e;
    endfunction

    // One clock: observe at negedge, update scoreboard, then cross the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk_i);
        check("ready_o", ready_o, !valid_o || ready_i);
        if (hold_chk) begin
            check("stall_valid", valid_o, 1'b1);
            check("stall_sum", sum_o, prev_sum);
            check("stall_cout", cout_o, prev_cout);
            check("stall_ovf", ovf_o, prev_ovf);
        end
        if (valid_o) begin
            if (q.size() == 0) begin
                check("spurious_valid", valid_o, 1'b0);
            end else begin
                check("sum", sum_o, q[0].sum);
                check("cout", cout_o, q[0].cout);
                check("ovf", ovf_o, q[0].ovf);
                if (!front_seen && chk_lat) check("latency", cyc - q[0].acc, 3);
                front_seen = 1;
                last_sum  = sum_o;
                last_cout = cout_o;
                last_ovf  = ovf_o;
            end
        end
        hold_chk  = valid_o && !ready_i;
        prev_sum  = sum_o;
        prev_cout = cout_o;
        prev_ovf  = ovf_o;
        if (valid_o && ready_i && q.size() > 0) begin
            void'(q.pop_front());
            front_seen = 0;
            n_res++;
        end
        if (valid_i && ready_o) begin
            e = model(a_i, b_i, cin_i, sub_i);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        valid_i = 1'b1;
        a_i = a; b_i = b; cin_i = cin; sub_i = sub;
        cycle();
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int base;
        // ---- reset state ----
        #2 rst_ni = 1'b0;
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_sum", sum_o, 32'h0);
        check("rst_cout", cout_o, 1'b0);
        check("rst_ovf", ovf_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // ---- carry ripple ----
        op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle(5);
        check("ripple_sum", last_sum, 32'h0);
        check("ripple_cout", last_cout, 1'b1);
        check("ripple_ovf", last_ovf, 1'b0);

        // ---- signed overflow ----
        op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle(5);
        check("ovf1_sum", last_sum, 32'h8000_0000);
        check("ovf1_cout", last_cout, 1'b0);
        check("ovf1_ovf", last_ovf, 1'b1);
        op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        idle(5);
        check("ovf2_sum", last_sum, 32'h0);
        check("ovf2_cout", last_cout, 1'b1);
        check("ovf2_ovf", last_ovf, 1'b1);

        // ---- throughput: latency check per result forces back-to-back output ----
        base = n_res;
        op(32'd1, 32'd1, 1'b0, 1'b0);
        op(32'd2, 32'd2, 1'b0, 1'b0);
        op(32'd3, 32'd3, 1'b0, 1'b0);
        op(32'hFFFF, 32'd1, 1'b0, 1'b0);
        idle(5);
        check("thru_count", n_res - base, 4);
        check("thru_last", last_sum, 32'h0001_0000);

`ifdef CLA_ADDER_SUB_EN
        // ---- subtract ----
        op(32'd5, 32'd7, 1'b0, 1'b1);
        idle(5);
        check("sub1_sum", last_sum, 32'hFFFF_FFFE);
        check("sub1_borrow", last_cout, 1'b1);
        check("sub1_ovf", last_ovf, 1'b0);
        op(32'd7, 32'd5, 1'b0, 1'b1);
        idle(5);
        check("sub2_sum", last_sum, 32'd2);
        check("sub2_borrow", last_cout, 1'b0);
`endif

        // ---- backpressure ----
        chk_lat = 0;
        base = n_res;
        op(32'h10, 32'h1, 1'b0, 1'b0);
        op(32'h20, 32'h2, 1'b1, 1'b0);
        op(32'h30, 32'h3, 1'b0, 1'b0);
        ready_i = 1'b0;
        op(32'h40, 32'h4, 1'b1, 1'b0);
        valid_i = 1'b1; a_i = 32'hDEAD; b_i = 32'hBEEF;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", ready_o, 1'b0);
            cycle();
        end
        ready_i = 1'b1;
        idle(8);
        check("bp_drained", n_res - base, 4);
        check("bp_empty", q.size(), 0);

        // ---- reset with three operations in flight ----
        chk_lat = 1;
        op(32'h100, 32'h1, 1'b0, 1'b0);
        op(32'h200, 32'h2, 1'b0, 1'b0);
        op(32'h300, 32'h3, 1'b0, 1'b0);
        idle(1);
        check("pre_rst_valid", valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_sum", sum_o, 32'h0);
        check("mid_rst_cout", cout_o, 1'b0);
        check("mid_rst_ovf", ovf_o, 1'b0);
        check("mid_rst_ready", ready_o, 1'b1);
        q.delete();
        front_seen = 0;
        hold_chk = 0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        base = n_res;
        idle(6);
        check("no_stale", n_res - base, 0);
        op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        idle(5);
        check("post_rst_count", n_res - base, 1);
        check("post_rst_sum", last_sum, 32'h2345_678A);

        // ---- random traffic with random backpressure ----
        chk_lat = 0;
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            a_i   = rnd32();
            b_i   = rnd32();
            cin_i = 1'($urandom_range(0, 1));
`ifdef CLA_ADDER_SUB_EN
            sub_i = 1'($urandom_range(0, 1));
`endif
            cycle();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 20 && (q.size() > 0 || valid_o); i++) cycle();
        check("final_empty", q.size(), 0);
        check("final_valid", valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
